uart_rx: RTL and testbench

- UART receive block, the receive counterpart of the team's uart_tx.
- Recovers 8N1/8N2 frames from the asynchronous rx pin using the same baud divisor and stop-bit configuration as the transmitter.
- Presents each good byte on a valid/ready handshake to the peripheral bus register logic.
- Flags framing and overrun errors.

---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8N2 receiver with valid/ready delivery,
// framing and overrun error pulses.
module uart_rx #(
  parameter int DATA_SIZE     = 8,
  parameter int BAUD_DIV_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_pin_i,
  input  logic [BAUD_DIV_SIZE-1:0] baud_div_i,
  input  logic                     two_stop_bits,
  output logic [DATA_SIZE-1:0]     rx_data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     frame_err_o,
  output logic                     overrun_o,
  output logic                     busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_SIZE - 1);
  localparam logic [BAUD_DIV_SIZE-1:0] ONE = BAUD_DIV_SIZE'(1);

  state_t state;
  state_t state_nx;

  logic                     rx_meta;
  logic                     rx_s;
  logic [BAUD_DIV_SIZE-1:0] cnt;
  logic [BAUD_DIV_SIZE-1:0] div_q;
  logic                     two_q;
  logic                     stop2_q;
  logic [3:0]               bit_idx;
  logic [DATA_SIZE-1:0]     shift_q;
  logic                     ovr_q;
  logic                     start_det;
  logic                     sample_pulse;
  logic                     deliver;
  logic                     more_stop;

  assign start_det    = (state == IDLE) && !rx_s;
  assign sample_pulse = (state == START || state == DATA ||
                         state == STOP) && (cnt == ONE);
  assign more_stop    = two_q && !stop2_q;
  assign overrun_o    = ovr_q;

  // Two-flop synchronizer for the asynchronous line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_pin_i;
      rx_s    <= rx_meta;
    end
  end

  // Bit timer; frame settings are frozen at start detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= '0;
      two_q <= 1'b0;
    end else if (start_det) begin
      cnt   <= baud_div_i >> 1;
      div_q <= baud_div_i;
      two_q <= two_stop_bits;
    end else if (sample_pulse) begin
      cnt <= div_q;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // Shift register, bit index and second-stop tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_idx <= '0;
      stop2_q <= 1'b0;
    end else if (sample_pulse) begin
      unique case (1'b1)
        state == START: begin
          bit_idx <= '0;
          stop2_q <= 1'b0;
        end
        state == DATA: begin
          shift_q <= {rx_s, shift_q[DATA_SIZE-1:1]};
          bit_idx <= bit_idx + 4'd1;
        end
        state == STOP: begin
          if (rx_s) stop2_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_nx = START;
      end
      START: begin
        if (sample_pulse) state_nx = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample_pulse && bit_idx == LAST_BIT) state_nx = STOP;
      end
      STOP: begin
        if (sample_pulse) begin
          if (!rx_s)          state_nx = WAIT_HIGH;
          else if (more_stop) state_nx = STOP;
          else                state_nx = IDLE;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-state outputs: error pulse, delivery strobe, busy.
  always_comb begin
    frame_err_o = 1'b0;
    deliver     = 1'b0;
    busy_o      = (state != IDLE);
    if (state == STOP && sample_pulse) begin
      frame_err_o = !rx_s;
      deliver     = rx_s && !more_stop;
    end
  end

  // Output holding register and valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_o <= '0;
      valid_o   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (deliver) begin
        if (!valid_o || ready_i) begin
          rx_data_o <= shift_q;
          valid_o   <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table vectors, hand sequences and random frames
// checked against a frame-level schedule model.
`timescale 1ns/1ps
module tb_uart_rx;

  logic        clk;
  logic        rst_n;
  logic        rx_pin;
  logic [15:0] baud_div;
  logic        two_stop;
  logic [7:0]  rx_data;
  logic        valid;
  logic        ready;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  logic rdy_man;
  logic rdy_rand;
  logic rdy_rnd;

  int checks;
  int errs;
  int cyc;

  logic [7:0] sched_del [int];
  bit         sched_fe  [int];
  logic       m_valid;
  logic [7:0] m_data;
  logic       ovr_now;
  logic [7:0] got_q [$];
  int         fe_cnt;
  int         ov_cnt;
  int         last_rise;

  typedef struct {
    int         n;
    bit         two;
    logic [7:0] data;
    bit         bad;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t tbl [8];

  uart_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_pin_i     (rx_pin),
    .baud_div_i   (baud_div),
    .two_stop_bits(two_stop),
    .rx_data_o    (rx_data),
    .valid_o      (valid),
    .ready_i      (ready),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  assign ready = rdy_rand ? rdy_rnd : rdy_man;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdy_rnd <= 1'($urandom_range(0, 1));
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic idle(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(logic b, int n);
    rx_pin = b;
    idle(n);
  endtask

  // Line-level frame: start, 8 data LSB first, stop bit(s).
  // The expected outcome is booked by the cycle of its last
  // stop sample: start edge + 2 sync + N/2 + bits*N.
  task automatic send_frame(int n, bit two, logic [7:0] d,
                            bit bad, bit scr, int hold);
    int base;
    base     = cyc + 2 + n / 2;
    baud_div = 16'(n);
    two_stop = two;
    if (bad) sched_fe[base + 9 * n] = 1'b1;
    else     sched_del[base + (9 + int'(two)) * n] = d;
    drive_bit(1'b0, n);
    if (scr) begin
      baud_div = 16'($urandom_range(4, 40));
      two_stop = ~two;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    drive_bit(!bad, n + hold);
    if (two) drive_bit(1'b1, n);
  endtask

  // Per-cycle comparison against the booked outcomes and the
  // handshake rules; advances the model to the next cycle.
  task automatic monitor();
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        ovr_now = 1'b0;
        sched_del.delete();
        sched_fe.delete();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        pv = 1'b0;
      end else begin
        chk("valid", 32'(valid), 32'(m_valid));
        chk("data", 32'(rx_data), 32'(m_data));
        chk("frame_err", 32'(frame_err), 32'(sched_fe.exists(cyc)));
        chk("overrun", 32'(overrun), 32'(ovr_now));
        if (valid && ready) got_q.push_back(rx_data);
        if (valid && !pv) last_rise = cyc;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        pv      = valid;
        ovr_now = 1'b0;
        if (sched_del.exists(cyc)) begin
          if (!m_valid || ready) begin
            m_valid = 1'b1;
            m_data  = sched_del[cyc];
          end else begin
            ovr_now = 1'b1;
          end
        end else if (m_valid && ready) begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int s;
    int n0;
    int fe0;
    int ov0;
    int g0;
    int n;
    bit two;
    bit bad;
    clk       = 1'b0;
    rst_n     = 1'b0;
    rx_pin    = 1'b1;
    baud_div  = 16'd16;
    two_stop  = 1'b0;
    rdy_man   = 1'b1;
    rdy_rand  = 1'b0;
    checks    = 0;
    errs      = 0;
    cyc       = 0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    ovr_now   = 1'b0;
    fe_cnt    = 0;
    ov_cnt    = 0;
    last_rise = -1;

    tbl[0] = '{16, 1'b0, 8'hA5, 1'b0, 8'hA5, 0};
    tbl[1] = '{5,  1'b0, 8'h00, 1'b0, 8'h00, 0};
    tbl[2] = '{5,  1'b0, 8'hFF, 1'b0, 8'hFF, 0};
    tbl[3] = '{5,  1'b0, 8'h81, 1'b0, 8'h81, 0};
    tbl[4] = '{16, 1'b1, 8'h3C, 1'b0, 8'h3C, 0};
    tbl[5] = '{7,  1'b0, 8'h12, 1'b1, 8'h3C, 1};
    tbl[6] = '{4,  1'b1, 8'hC3, 1'b0, 8'hC3, 0};
    tbl[7] = '{9,  1'b0, 8'h6E, 1'b0, 8'h6E, 0};

    fork
      monitor();
    join_none

    idle(3);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_data", 32'(rx_data), 0);
    chk("reset_ferr", 32'(frame_err), 0);
    chk("reset_ovr", 32'(overrun), 0);
    chk("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 8; i++) begin
      s   = cyc;
      fe0 = fe_cnt;
      g0  = got_q.size();
      send_frame(tbl[i].n, tbl[i].two, tbl[i].data, tbl[i].bad, 1'b0, 0);
      rx_pin = 1'b1;
      idle(tbl[i].n + 4);
      chk($sformatf("tbl%0d_data", i), 32'(rx_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_fe", i), 32'(fe_cnt - fe0), 32'(tbl[i].exp_fe));
      chk($sformatf("tbl%0d_got", i), 32'(got_q.size() - g0),
          32'(!tbl[i].bad));
      if (!tbl[i].bad)
        chk($sformatf("tbl%0d_rise", i), 32'(last_rise),
            32'(s + 3 + tbl[i].n / 2 + (9 + int'(tbl[i].two)) * tbl[i].n));
    end

    // Two back-to-back 8N2 frames with no consumer: overrun.
    rdy_man = 1'b0;
    ov0 = ov_cnt;
    send_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 0);
    send_frame(16, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
    idle(4);
    chk("ovr_count", 32'(ov_cnt - ov0), 1);
    chk("ovr_valid", 32'(valid), 1);
    chk("ovr_keep", 32'(rx_data), 32'h3C);
    rdy_man = 1'b1;
    idle(1);
    chk("ovr_drain", 32'(valid), 0);

    // Bad stop then a held-low break, then a clean frame.
    fe0 = fe_cnt;
    send_frame(16, 1'b0, 8'h55, 1'b1, 1'b0, 40);
    chk("brk_busy", 32'(busy), 1);
    chk("brk_fe", 32'(fe_cnt - fe0), 1);
    rx_pin = 1'b1;
    idle(20);
    chk("brk_idle", 32'(busy), 0);
    g0 = got_q.size();
    send_frame(16, 1'b0, 8'h81, 1'b0, 1'b0, 0);
    idle(20);
    chk("brk_next", 32'(got_q.size() - g0), 1);
    if (got_q.size() > 0) chk("brk_byte", 32'(got_q[$]), 32'h81);

    // Short glitch rejected at mid start bit.
    fe0 = fe_cnt;
    g0  = got_q.size();
    rx_pin = 1'b0;
    idle(4);
    rx_pin = 1'b1;
    idle(1);
    chk("gl_busy", 32'(busy), 1);
    idle(30);
    chk("gl_idle", 32'(busy), 0);
    chk("gl_fe", 32'(fe_cnt - fe0), 0);
    chk("gl_got", 32'(got_q.size() - g0), 0);

    // Odd divisor stream, back-to-back.
    g0 = got_q.size();
    send_frame(5, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    send_frame(5, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
    send_frame(5, 1'b0, 8'h81, 1'b0, 1'b0, 0);
    idle(20);
    chk("str_cnt", 32'(got_q.size() - g0), 3);
    if (got_q.size() >= g0 + 3) begin
      chk("str_b0", 32'(got_q[g0]), 32'h00);
      chk("str_b1", 32'(got_q[g0 + 1]), 32'hFF);
      chk("str_b2", 32'(got_q[g0 + 2]), 32'h81);
    end

    // Reset in the middle of a frame with a byte pending.
    rdy_man = 1'b0;
    send_frame(16, 1'b0, 8'h99, 1'b0, 1'b0, 0);
    idle(20);
    chk("pre_rst_valid", 32'(valid), 1);
    rx_pin = 1'b0;
    idle(16);
    rx_pin = 1'b1;
    idle(40);
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 0);
    chk("arst_data", 32'(rx_data), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ferr", 32'(frame_err), 0);
    chk("arst_ovr", 32'(overrun), 0);
    idle(3);
    rst_n   = 1'b1;
    rdy_man = 1'b1;
    idle(5);
    g0 = got_q.size();
    send_frame(16, 1'b0, 8'h42, 1'b0, 1'b0, 0);
    idle(20);
    chk("post_rst_cnt", 32'(got_q.size() - g0), 1);
    if (got_q.size() > 0) chk("post_rst_byte", 32'(got_q[$]), 32'h42);

    // Random frames, random consumer, settings scrambled mid-frame.
    rdy_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      n   = $urandom_range(4, 12);
      two = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(n, two, 8'($urandom), bad, 1'b1, 0);
      rx_pin = 1'b1;
      if (bad) idle(n * (1 + $urandom_range(0, 2)));
      else     idle(n * $urandom_range(0, 2));
    end
    rdy_rand = 1'b0;
    rdy_man  = 1'b1;
    idle(200);
    chk("end_valid", 32'(valid), 0);
    chk("end_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
